fpga_sram_sdp: RTL and testbench

FPGA_SRAM_SDP -- requirements
Module: fpga_sram_sdp

---
 rtl/fpga_sram_pkg.sv | 18 +
 rtl/fpga_sram_rd_stage.sv | 88 ++++++++
 rtl/fpga_sram_sdp.sv | 70 +++++++
 tb/tb_fpga_sram_sdp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fpga_sram_pkg.sv
// Shared constants for the simple dual-port SRAM wrapper: read-during-write
// mode codes and the mapping from the requested style to the RAM attribute.
package fpga_sram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  localparam int STYLE_W = 96;
  typedef logic [STYLE_W-1:0] style_t;

  // Unknown styles fall back to block RAM so a typo never yields a flop array.
  function automatic style_t ram_style_attr(input style_t v_style);
    if (v_style == style_t'("distributed")) return style_t'("distributed");
    else if (v_style == style_t'("ultra")) return style_t'("ultra");
    else return style_t'("block");
  endfunction

endpackage

// File: rtl/fpga_sram_rd_stage.sv
// Read output stage: collision merge after the RAM read register, optional
// output pipeline register, RVALID pipeline and RDATA hold.
module fpga_sram_rd_stage
  import fpga_sram_pkg::*;
#(
  parameter int DW       = 32,
  parameter int OUT_REG  = 0,
  parameter int RDW_MODE = RDW_OLD,
  localparam int NB      = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_acc,
  input  logic          col,
  input  logic [DW-1:0] wdata,
  input  logic [NB-1:0] wren,
  input  logic [DW-1:0] ram_q,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  logic          v0;
  logic          col0;
  logic [NB-1:0] msk0;
  logic [DW-1:0] wd0;
  logic          v1;
  logic [DW-1:0] rd1;
  logic [DW-1:0] merged;

  // Tag each accepted read; the collision flag only matters in new-data mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0   <= 1'b0;
      col0 <= 1'b0;
      msk0 <= '0;
      wd0  <= '0;
    end else begin
      v0 <= rd_acc;
      if (rd_acc) begin
        col0 <= (RDW_MODE == RDW_NEW) && col;
        msk0 <= wren;
        wd0  <= wdata;
      end
    end
  end

  // Replace enabled lanes of the stale RAM word with the colliding write data.
  always_comb begin
    merged = ram_q;
    for (int i = 0; i < NB; i++) begin
      if (col0 && msk0[i]) merged[8*i +: 8] = wd0[8*i +: 8];
    end
  end

  // First output register; loads only when a read completes so RDATA holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      rd1 <= '0;
    end else begin
      v1 <= v0;
      if (v0) rd1 <= merged;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic          v2;
    logic [DW-1:0] rd2;

    // Extra pipeline register for timing closure on wide/deep arrays.
    always_ff @(posedge clk) begin
      if (rst) begin
        v2  <= 1'b0;
        rd2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) rd2 <= rd1;
      end
    end

    assign rdata  = rd2;
    assign rvalid = v2;
  end else begin : g_no_out_reg
    assign rdata  = rd1;
    assign rvalid = v1;
  end

endmodule

// File: rtl/fpga_sram_sdp.sv
// Simple dual-port SRAM: one byte-enabled write port, one read port, single
// clock. Each byte lane is its own array so tools infer byte-write BRAM.
module fpga_sram_sdp
  import fpga_sram_pkg::*;
#(
  parameter int     AW       = 16,
  parameter int     DW       = 32,
  parameter int     OUT_REG  = 0,
  parameter int     RDW_MODE = RDW_OLD,
  parameter style_t V_STYLE  = "block",
  localparam int    NB       = DW / 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] WADDR,
  input  logic [DW-1:0] WDATA,
  input  logic [NB-1:0] WREN,
  input  logic          WCS,
  input  logic [AW-1:0] RADDR,
  input  logic          RCS,
  output logic [DW-1:0] RDATA,
  output logic          RVALID
);

  localparam int     DEPTH     = 2 ** AW;
  localparam style_t RAM_STYLE = ram_style_attr(V_STYLE);

  logic          wr_ok;
  logic          rd_acc;
  logic          col;
  logic [DW-1:0] ram_q;

  assign wr_ok  = WCS && !RST;
  assign rd_acc = RCS && !RST;
  assign col    = wr_ok && rd_acc && (WADDR == RADDR);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    (* ram_style = RAM_STYLE *) logic [7:0] mem [DEPTH];
    logic [7:0] q;

    // Lane write; contents are never reset.
    always_ff @(posedge CLK) begin
      if (wr_ok && WREN[i]) mem[WADDR] <= WDATA[8*i +: 8];
    end

    // Synchronous read register; a same-edge write is not yet visible (old data).
    always_ff @(posedge CLK) begin
      if (rd_acc) q <= mem[RADDR];
    end

    assign ram_q[8*i +: 8] = q;
  end

  fpga_sram_rd_stage #(
    .DW       (DW),
    .OUT_REG  (OUT_REG),
    .RDW_MODE (RDW_MODE)
  ) u_rd_stage (
    .clk    (CLK),
    .rst    (RST),
    .rd_acc (rd_acc),
    .col    (col),
    .wdata  (WDATA),
    .wren   (WREN),
    .ram_q  (ram_q),
    .rdata  (RDATA),
    .rvalid (RVALID)
  );

endmodule

// File: tb/tb_fpga_sram_sdp.sv
// Bench for fpga_sram_sdp: three instances share one stimulus bus.
//   u_a: AW=16, OUT_REG=0, old-data collisions
//   u_b: AW=16, OUT_REG=1, new-data collisions
//   u_c: AW=4,  OUT_REG=0, new-data collisions
module tb_fpga_sram_sdp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] waddr = '0;
  logic [15:0] raddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wren = '0;
  logic        wcs = 1'b0;
  logic        rcs = 1'b0;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpga_sram_sdp #(.AW(16), .DW(32), .OUT_REG(0), .RDW_MODE(0)) u_a (
    .CLK(clk), .RST(rst), .WADDR(waddr), .WDATA(wdata), .WREN(wren), .WCS(wcs),
    .RADDR(raddr), .RCS(rcs), .RDATA(rdata_a), .RVALID(rvalid_a)
  );

  fpga_sram_sdp #(.AW(16), .DW(32), .OUT_REG(1), .RDW_MODE(1), .V_STYLE("ultra")) u_b (
    .CLK(clk), .RST(rst), .WADDR(waddr), .WDATA(wdata), .WREN(wren), .WCS(wcs),
    .RADDR(raddr), .RCS(rcs), .RDATA(rdata_b), .RVALID(rvalid_b)
  );

  fpga_sram_sdp #(.AW(4), .DW(32), .OUT_REG(0), .RDW_MODE(1), .V_STYLE("distributed")) u_c (
    .CLK(clk), .RST(rst), .WADDR(waddr[3:0]), .WDATA(wdata), .WREN(wren), .WCS(wcs),
    .RADDR(raddr[3:0]), .RCS(rcs), .RDATA(rdata_c), .RVALID(rvalid_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] en);
    wcs = 1'b1; waddr = a; wdata = d; wren = en;
    step();
    wcs = 1'b0; wren = '0;
  endtask

  task automatic rd(input logic [15:0] a);
    rcs = 1'b1; raddr = a;
    step();
    rcs = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if ({rvalid_a, rdata_a} !== 33'h0) begin bad++; $display("FAIL reset_a: got %0b/%h want 0/00000000", rvalid_a, rdata_a); end
    total++; if ({rvalid_b, rdata_b} !== 33'h0) begin bad++; $display("FAIL reset_b: got %0b/%h want 0/00000000", rvalid_b, rdata_b); end
    total++; if ({rvalid_c, rdata_c} !== 33'h0) begin bad++; $display("FAIL reset_c: got %0b/%h want 0/00000000", rvalid_c, rdata_c); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    wr(16'd5, 32'hDEADBEEF, 4'hF);
    rd(16'd5);
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_rd_a: got %0b/%h want 1/deadbeef", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_rd_c: got %0b/%h want 1/deadbeef", rvalid_c, rdata_c); end
    total++; if (rvalid_b !== 1'b0) begin bad++; $display("FAIL wr_rd_b_early: got rvalid %0b want 0", rvalid_b); end
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_rd_a_hold: got %0b/%h want 0/deadbeef", rvalid_a, rdata_a); end
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_rd_b: got %0b/%h want 1/deadbeef", rvalid_b, rdata_b); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b0, 32'hDEADBEEF}) begin bad++; $display("FAIL wr_rd_b_hold: got %0b/%h want 0/deadbeef", rvalid_b, rdata_b); end
  endtask

  task automatic test_byte_enable();
    wr(16'd5, 32'h11223344, 4'h5);
    wr(16'd5, 32'hFFFFFFFF, 4'h0);
    rd(16'd5);
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hDE22BE44}) begin bad++; $display("FAIL be_a: got %0b/%h want 1/de22be44", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'hDE22BE44}) begin bad++; $display("FAIL be_c: got %0b/%h want 1/de22be44", rvalid_c, rdata_c); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hDE22BE44}) begin bad++; $display("FAIL be_b: got %0b/%h want 1/de22be44", rvalid_b, rdata_b); end
  endtask

  task automatic test_collision();
    wr(16'd7, 32'hAAAAAAAA, 4'hF);
    wcs = 1'b1; waddr = 16'd7; wdata = 32'h55555555; wren = 4'h3;
    rcs = 1'b1; raddr = 16'd7;
    step();
    wcs = 1'b0; wren = '0; rcs = 1'b0;
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hAAAAAAAA}) begin bad++; $display("FAIL col_old_a: got %0b/%h want 1/aaaaaaaa", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL col_new_c: got %0b/%h want 1/aaaa5555", rvalid_c, rdata_c); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL col_new_b: got %0b/%h want 1/aaaa5555", rvalid_b, rdata_b); end
    rd(16'd7);
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL col_after_a: got %0b/%h want 1/aaaa5555", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL col_after_c: got %0b/%h want 1/aaaa5555", rvalid_c, rdata_c); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL col_after_b: got %0b/%h want 1/aaaa5555", rvalid_b, rdata_b); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    logic [32:0] exp_a, exp_b;
    w[0] = 32'hC0DE0000; w[1] = 32'hC0DE1111; w[2] = 32'hC0DE2222; w[3] = 32'hC0DE3333;
    for (int i = 0; i < 4; i++) wr(16'(i), w[i], 4'hF);
    for (int t = 0; t < 6; t++) begin
      rcs = (t < 4); raddr = 16'(t & 3);
      step();
      rcs = 1'b0;
      exp_a = (t == 0) ? {1'b0, 32'hAAAA5555} : {(t <= 4), w[(t - 1 > 3) ? 3 : t - 1]};
      exp_b = (t < 2)  ? {1'b0, 32'hAAAA5555} : {1'b1, w[t - 2]};
      total++; if ({rvalid_a, rdata_a} !== exp_a) begin bad++; $display("FAIL b2b_a t=%0d: got %0b/%h want %0b/%h", t, rvalid_a, rdata_a, exp_a[32], exp_a[31:0]); end
      total++; if ({rvalid_c, rdata_c} !== exp_a) begin bad++; $display("FAIL b2b_c t=%0d: got %0b/%h want %0b/%h", t, rvalid_c, rdata_c, exp_a[32], exp_a[31:0]); end
      total++; if ({rvalid_b, rdata_b} !== exp_b) begin bad++; $display("FAIL b2b_b t=%0d: got %0b/%h want %0b/%h", t, rvalid_b, rdata_b, exp_b[32], exp_b[31:0]); end
    end
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if ({rvalid_a, rdata_a} !== {1'b0, w[3]}) begin bad++; $display("FAIL idle_hold_a k=%0d: got %0b/%h want 0/%h", k, rvalid_a, rdata_a, w[3]); end
      total++; if ({rvalid_b, rdata_b} !== {1'b0, w[3]}) begin bad++; $display("FAIL idle_hold_b k=%0d: got %0b/%h want 0/%h", k, rvalid_b, rdata_b, w[3]); end
      total++; if ({rvalid_c, rdata_c} !== {1'b0, w[3]}) begin bad++; $display("FAIL idle_hold_c k=%0d: got %0b/%h want 0/%h", k, rvalid_c, rdata_c, w[3]); end
    end
  endtask

  task automatic test_reset_inflight();
    rd(16'd5);
    rst = 1'b1;
    wcs = 1'b1; waddr = 16'd5; wdata = 32'h0; wren = 4'hF;
    rcs = 1'b1; raddr = 16'd5;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if ({rvalid_a, rdata_a} !== 33'h0) begin bad++; $display("FAIL rst_in_a k=%0d: got %0b/%h want 0/00000000", k, rvalid_a, rdata_a); end
      total++; if ({rvalid_b, rdata_b} !== 33'h0) begin bad++; $display("FAIL rst_in_b k=%0d: got %0b/%h want 0/00000000", k, rvalid_b, rdata_b); end
      total++; if ({rvalid_c, rdata_c} !== 33'h0) begin bad++; $display("FAIL rst_in_c k=%0d: got %0b/%h want 0/00000000", k, rvalid_c, rdata_c); end
    end
    rst = 1'b0; wcs = 1'b0; wren = '0; rcs = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if ({rvalid_a, rdata_a} !== 33'h0) begin bad++; $display("FAIL rst_post_a k=%0d: got %0b/%h want 0/00000000", k, rvalid_a, rdata_a); end
      total++; if ({rvalid_b, rdata_b} !== 33'h0) begin bad++; $display("FAIL rst_post_b k=%0d: got %0b/%h want 0/00000000", k, rvalid_b, rdata_b); end
      total++; if ({rvalid_c, rdata_c} !== 33'h0) begin bad++; $display("FAIL rst_post_c k=%0d: got %0b/%h want 0/00000000", k, rvalid_c, rdata_c); end
    end
    rd(16'd5);
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hDE22BE44}) begin bad++; $display("FAIL mem_kept_a: got %0b/%h want 1/de22be44", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'hDE22BE44}) begin bad++; $display("FAIL mem_kept_c: got %0b/%h want 1/de22be44", rvalid_c, rdata_c); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hDE22BE44}) begin bad++; $display("FAIL mem_kept_b: got %0b/%h want 1/de22be44", rvalid_b, rdata_b); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(16'd7);
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL first_op_a: got %0b/%h want 1/aaaa5555", rvalid_a, rdata_a); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hAAAA5555}) begin bad++; $display("FAIL first_op_b: got %0b/%h want 1/aaaa5555", rvalid_b, rdata_b); end
  endtask

  task automatic test_no_alias();
    wr(16'd15, 32'hF00DF00D, 4'hF);
    wr(16'd0,  32'h0BADCAFE, 4'hF);
    rcs = 1'b1; raddr = 16'd15;
    step();
    raddr = 16'd0;
    step();
    rcs = 1'b0;
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'hF00DF00D}) begin bad++; $display("FAIL alias15_a: got %0b/%h want 1/f00df00d", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'hF00DF00D}) begin bad++; $display("FAIL alias15_c: got %0b/%h want 1/f00df00d", rvalid_c, rdata_c); end
    step();
    total++; if ({rvalid_a, rdata_a} !== {1'b1, 32'h0BADCAFE}) begin bad++; $display("FAIL alias0_a: got %0b/%h want 1/0badcafe", rvalid_a, rdata_a); end
    total++; if ({rvalid_c, rdata_c} !== {1'b1, 32'h0BADCAFE}) begin bad++; $display("FAIL alias0_c: got %0b/%h want 1/0badcafe", rvalid_c, rdata_c); end
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'hF00DF00D}) begin bad++; $display("FAIL alias15_b: got %0b/%h want 1/f00df00d", rvalid_b, rdata_b); end
    step();
    total++; if ({rvalid_b, rdata_b} !== {1'b1, 32'h0BADCAFE}) begin bad++; $display("FAIL alias0_b: got %0b/%h want 1/0badcafe", rvalid_b, rdata_b); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_reset_inflight();
    test_no_alias();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
